// File: rtl/divider_seq_unit_if.sv
// divider_seq_unit_if: operand/result handshake bundle between issue logic and the sequential divider
interface divider_seq_unit_if #(parameter int WIDTH = 32);
  logic startValid;
  logic startReady;
  logic sign;
  logic [WIDTH-1:0] dividendIn;
  logic [WIDTH-1:0] divisorIn;
  logic abort;
  logic resultValid;
  logic resultReady;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic divError;
  modport master (
    output startValid, sign, dividendIn, divisorIn, abort, resultReady,
    input  startReady, resultValid, quotient, remainder, divError
  );
  modport slave (
    input  startValid, sign, dividendIn, divisorIn, abort, resultReady,
    output startReady, resultValid, quotient, remainder, divError
  );
endinterface

// File: rtl/divider_seq_unit.sv
// divider_seq_unit: restoring divider, one quotient bit per cycle, signed/unsigned, abortable.
// Define DIVIDER_SEQ_UNIT_EARLY_OUT_EN to finish in one cycle when |dividend| < |divisor|.
module divider_seq_unit #(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic reset,
  divider_seq_unit_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, DIVIDE, FIXUP, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] dvd, dvs, rem, a_mag, b_mag;
  logic [WIDTH:0] shifted, trial;
  logic [CNT_W-1:0] cnt;
  logic q_neg, r_neg, zero, early;
  always_comb begin
    a_mag = (bus.sign && bus.dividendIn[WIDTH-1]) ? -bus.dividendIn : bus.dividendIn;
    b_mag = (bus.sign && bus.divisorIn[WIDTH-1]) ? -bus.divisorIn : bus.divisorIn;
    zero = ~|bus.divisorIn;
`ifdef DIVIDER_SEQ_UNIT_EARLY_OUT_EN
    early = !zero && (a_mag < b_mag);
`else
    early = 1'b0;
`endif
    shifted = {rem, dvd[WIDTH-1]};
    trial = shifted - {1'b0, dvs};
  end
  // dvd doubles as the quotient register: dividend bits shift out as quotient bits shift in
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bus.startReady <= 1'b1;
      bus.resultValid <= 1'b0;
      bus.divError <= 1'b0;
      bus.quotient <= '0;
      bus.remainder <= '0;
      cnt <= '0;
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (bus.abort && state != IDLE) begin
      state <= IDLE;
      bus.startReady <= 1'b1;
      bus.resultValid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.startValid && !bus.abort) begin
          dvd <= a_mag;
          dvs <= b_mag;
          q_neg <= bus.sign && (bus.dividendIn[WIDTH-1] ^ bus.divisorIn[WIDTH-1]);
          r_neg <= bus.sign && bus.dividendIn[WIDTH-1];
          rem <= '0;
          cnt <= '0;
          bus.startReady <= 1'b0;
          bus.divError <= zero;
          if (zero || early) begin
            state <= DONE;
            bus.resultValid <= 1'b1;
            bus.quotient <= {WIDTH{zero}};
            bus.remainder <= bus.dividendIn;
          end else begin
            state <= DIVIDE;
          end
        end
        DIVIDE: begin
          rem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          dvd <= {dvd[WIDTH-2:0], ~trial[WIDTH]};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= FIXUP;
        end
        FIXUP: begin
          bus.quotient <= q_neg ? -dvd : dvd;
          bus.remainder <= r_neg ? -rem : rem;
          bus.resultValid <= 1'b1;
          state <= DONE;
        end
        DONE: if (bus.resultReady) begin
          state <= IDLE;
          bus.resultValid <= 1'b0;
          bus.startReady <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_divider_seq_unit.sv
// tb_divider_seq_unit: vector table, corner sequences and randomized ops against an arithmetic reference model
module tb_divider_seq_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
`ifdef DIVIDER_SEQ_UNIT_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  divider_seq_unit_if #(.WIDTH(32)) if32();
  divider_seq_unit_if #(.WIDTH(16)) if16();
  divider_seq_unit_if #(.WIDTH(8))  if8();
  divider_seq_unit #(.WIDTH(32)) u32 (.clk(clk), .reset(reset), .bus(if32.slave));
  divider_seq_unit #(.WIDTH(16)) u16 (.clk(clk), .reset(reset), .bus(if16.slave));
  divider_seq_unit #(.WIDTH(8))  u8  (.clk(clk), .reset(reset), .bus(if8.slave));
  int tests = 0;
  int fails = 0;
  int hs32 = 0;
  always @(posedge clk) if (!reset && if32.resultValid && if32.resultReady) hs32++;
  typedef struct {
    bit sg;
    logic [31:0] a, b, q, r;
    bit e;
  } vec_t;
  vec_t tbl[9];
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  function automatic longint unsigned mag(input int w, input bit sg, input longint unsigned v);
    longint unsigned m = (64'd1 << w) - 64'd1;
    return (sg && v[w-1]) ? (((64'd1 << w) - v) & m) : v;
  endfunction
  function automatic int exp_lat(input int w, input bit sg, input longint unsigned a, input longint unsigned b);
    if (b == 0) return 1;
    if (EARLY && mag(w, sg, a) < mag(w, sg, b)) return 1;
    return w + 2;
  endfunction
  // truncating division on plain integers; remainder sign follows the dividend
  function automatic void model(input int w, input bit sg, input longint unsigned a, input longint unsigned b,
                                output longint unsigned q, output longint unsigned r, output bit e);
    longint unsigned m = (64'd1 << w) - 64'd1;
    longint sa, sb;
    e = 1'b0;
    if (b == 0) begin
      q = m; r = a; e = 1'b1;
    end else if (sg) begin
      sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
      sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
      q = longint'(sa / sb) & m;
      r = longint'(sa % sb) & m;
    end else begin
      q = (a / b) & m;
      r = (a % b) & m;
    end
  endfunction
  task automatic run32(input bit sg, input logic [31:0] a, input logic [31:0] b, input int stall,
                       output logic [31:0] q, output logic [31:0] r, output logic e, output int lat);
    int g = 0;
    while (!if32.startReady && g < 100) begin @(posedge clk); #1; g++; end
    if32.sign = sg; if32.dividendIn = a; if32.divisorIn = b; if32.startValid = 1'b1;
    @(posedge clk); #1;
    if32.startValid = 1'b0; if32.sign = $urandom; if32.dividendIn = $urandom; if32.divisorIn = $urandom;
    lat = 1;
    while (!if32.resultValid && lat < 100) begin @(posedge clk); #1; lat++; end
    q = if32.quotient; r = if32.remainder; e = if32.divError;
    repeat (stall) begin @(posedge clk); #1; end
    if32.resultReady = 1'b1;
    @(posedge clk); #1;
    if32.resultReady = 1'b0;
  endtask
  task automatic run16(input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] q, output logic [15:0] r, output int lat);
    int g = 0;
    while (!if16.startReady && g < 100) begin @(posedge clk); #1; g++; end
    if16.sign = 1'b0; if16.dividendIn = a; if16.divisorIn = b; if16.startValid = 1'b1;
    @(posedge clk); #1;
    if16.startValid = 1'b0;
    lat = 1;
    while (!if16.resultValid && lat < 100) begin @(posedge clk); #1; lat++; end
    q = if16.quotient; r = if16.remainder;
    if16.resultReady = 1'b1;
    @(posedge clk); #1;
    if16.resultReady = 1'b0;
  endtask
  initial begin
    logic [31:0] q, r;
    logic [15:0] q16, r16;
    logic e;
    int lat, seen, base;
    longint unsigned eq, er;
    bit ee, sg;
    logic [31:0] a, b;
    tbl[0] = '{0, 32'd100, 32'd7, 32'd14, 32'd2, 0};
    tbl[1] = '{1, -32'sd100, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 0};
    tbl[2] = '{1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 0};
    tbl[3] = '{1, 32'd100, -32'sd7, 32'hFFFFFFF2, 32'd2, 0};
    tbl[4] = '{0, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'hF, 0};
    tbl[5] = '{0, 32'd3, 32'd10, 32'd0, 32'd3, 0};
    tbl[6] = '{0, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1};
    tbl[7] = '{1, -32'sd7, -32'sd2, 32'd3, 32'hFFFFFFFF, 0};
    tbl[8] = '{0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 0};
    {if32.startValid, if32.abort, if32.resultReady, if32.sign} = '0;
    {if16.startValid, if16.abort, if16.resultReady, if16.sign} = '0;
    {if8.startValid, if8.abort, if8.resultReady, if8.sign} = '0;
    if32.dividendIn = '0; if32.divisorIn = '0;
    if16.dividendIn = '0; if16.divisorIn = '0;
    if8.dividendIn = '0; if8.divisorIn = '0;
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_state", {if32.startReady, if32.resultValid, if32.divError}, 3'b100);
    chk("rst_q", if32.quotient, 0);
    chk("rst_r", if32.remainder, 0);
    reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      run32(tbl[i].sg, tbl[i].a, tbl[i].b, i % 3, q, r, e, lat);
      chk($sformatf("tbl%0d_q", i), q, tbl[i].q);
      chk($sformatf("tbl%0d_r", i), r, tbl[i].r);
      chk($sformatf("tbl%0d_err", i), e, tbl[i].e);
      chk($sformatf("tbl%0d_lat", i), lat, exp_lat(32, tbl[i].sg, tbl[i].a, tbl[i].b));
    end
    // divide by zero on the 8-bit unit, result held while the consumer stalls
    if8.sign = 1'b1; if8.dividendIn = 8'h55; if8.divisorIn = 8'h00; if8.startValid = 1'b1;
    @(posedge clk); #1;
    if8.startValid = 1'b0; if8.dividendIn = 8'hAA;
    chk("z8_result", {if8.resultValid, if8.quotient, if8.remainder, if8.divError}, {1'b1, 8'hFF, 8'h55, 1'b1});
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("z8_hold", {if8.resultValid, if8.startReady, if8.quotient, if8.remainder, if8.divError},
          {1'b1, 1'b0, 8'hFF, 8'h55, 1'b1});
    end
    if8.resultReady = 1'b1;
    @(posedge clk); #1;
    if8.resultReady = 1'b0;
    chk("z8_release", {if8.resultValid, if8.startReady}, 2'b01);
    // 16-bit: full run, abort mid-divide, abort blocking accept in idle, then a fresh op
    run16(16'hFFFF, 16'h0003, q16, r16, lat);
    chk("w16_q", q16, 16'h5555);
    chk("w16_r", r16, 16'h0000);
    chk("w16_lat", lat, 18);
    if16.dividendIn = 16'hFFFF; if16.divisorIn = 16'h0003; if16.startValid = 1'b1;
    @(posedge clk); #1;
    if16.startValid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    if16.abort = 1'b1;
    @(posedge clk); #1;
    if16.abort = 1'b0;
    chk("ab_idle", {if16.startReady, if16.resultValid}, 2'b10);
    seen = 0;
    repeat (25) begin @(posedge clk); #1; if (if16.resultValid) seen++; end
    chk("ab_novalid", seen, 0);
    if16.startValid = 1'b1; if16.abort = 1'b1;
    @(posedge clk); #1;
    if16.startValid = 1'b0; if16.abort = 1'b0;
    chk("ab_blocks_accept", if16.startReady, 1'b1);
    run16(16'd3, 16'd2, q16, r16, lat);
    chk("ab_next", {q16, r16}, {16'd1, 16'd1});
    chk("ab_next_lat", lat, 18);
    // reset in the middle of a 32-bit divide
    if32.sign = 1'b0; if32.dividendIn = 32'hFFFFFFFF; if32.divisorIn = 32'd7; if32.startValid = 1'b1;
    @(posedge clk); #1;
    if32.startValid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst", {if32.startReady, if32.resultValid, if32.quotient}, {1'b1, 1'b0, 32'd0});
    run32(1'b0, 32'd3, 32'd10, 0, q, r, e, lat);
    chk("post_rst_qr", {q, r}, {32'd0, 32'd3});
    chk("post_rst_lat", lat, EARLY ? 1 : 34);
    // randomized back-to-back ops with consumer stalls
    base = hs32;
    for (int i = 0; i < 20; i++) begin
      sg = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; sg = 1'b1; end
        2: b = $urandom_range(1, 15);
        3: b = $urandom & 32'hFFFF;
        4: begin b = $urandom; a = a & 32'hFF; end
        default: b = $urandom;
      endcase
      model(32, sg, a, b, eq, er, ee);
      run32(sg, a, b, $urandom_range(0, 3), q, r, e, lat);
      chk($sformatf("rnd%0d_q", i), q, eq);
      chk($sformatf("rnd%0d_r", i), r, er);
      chk($sformatf("rnd%0d_err", i), e, ee);
      chk($sformatf("rnd%0d_lat", i), lat, exp_lat(32, sg, a, b));
    end
    @(posedge clk); #1;
    chk("rnd_handshakes", hs32 - base, 20);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
